// File: rtl/mini_micro_ctrl_if.sv
// Bus bundle between the miniMicro sequencer and its program memory,
// register memory and ALU. master = sequencer, slave = memories/ALU side.
`timescale 1ns/1ps
interface mini_micro_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned OPC_WIDTH  = 5;
  localparam int unsigned FLAG_WIDTH = 4;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [ADDR_WIDTH-1:0] rf_addr;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic [DATA_WIDTH-1:0] rf_rdata;
  logic [OPC_WIDTH-1:0]  alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [FLAG_WIDTH-1:0] alu_flags;

  modport master (
    output imem_addr, rf_addr, rf_we, rf_wdata, alu_op, alu_a, alu_b,
    input  imem_rdata, rf_rdata, alu_result, alu_flags
  );

  modport slave (
    input  imem_addr, rf_addr, rf_we, rf_wdata, alu_op, alu_a, alu_b,
    output imem_rdata, rf_rdata, alu_result, alu_flags
  );
endinterface

// File: rtl/mini_micro_ctrl.sv
// miniMicro multi-cycle sequencer: owns the PC, fetches and decodes
// instruction words, sequences operand reads through the single-port
// register memory, drives the ALU and writes results back.
// Optional feature macro: MINI_MICRO_CTRL_STEP_EN (adds a single-step input).
// alu_a, alu_b and rf_wdata are gated views of registered state or of the
// memory/ALU registered outputs, because that data only arrives in the cycle
// it is consumed; every other output is a flop.
`timescale 1ns/1ps
module mini_micro_ctrl #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
`ifdef MINI_MICRO_CTRL_STEP_EN
  input  logic                 step,
`endif
  mini_micro_ctrl_if.master    bus,
  output logic [3:0]           flags,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int unsigned OPC_WIDTH = 5;
  localparam int unsigned RD_LSB    = OPC_WIDTH;
  localparam int unsigned RS1_LSB   = OPC_WIDTH + ADDR_WIDTH;
  localparam int unsigned RS2_LSB   = OPC_WIDTH + 2 * ADDR_WIDTH;
  localparam logic [OPC_WIDTH-1:0] OP_NOP = 5'd0;
  localparam logic [OPC_WIDTH-1:0] OP_CMP = 5'd18;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RS1, S_RS2, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] a;
`ifdef MINI_MICRO_CTRL_STEP_EN
  logic                  single_step;
`endif

  logic [OPC_WIDTH-1:0]  opcode;
  logic [ADDR_WIDTH-1:0] rd;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [OPC_WIDTH-1:0]  fetch_op;
  logic [ADDR_WIDTH-1:0] fetch_rs1;

  // Instruction field split of the latched word and of the word arriving in DECODE.
  assign opcode    = ir[OPC_WIDTH-1:0];
  assign rd        = ir[RD_LSB +: ADDR_WIDTH];
  assign rs2       = ir[RS2_LSB +: ADDR_WIDTH];
  assign fetch_op  = bus.imem_rdata[OPC_WIDTH-1:0];
  assign fetch_rs1 = bus.imem_rdata[RS1_LSB +: ADDR_WIDTH];

  // Data that only becomes valid in the consuming cycle is gated by state.
  assign bus.imem_addr = pc;
  assign bus.alu_a     = (state == S_EXEC) ? a : '0;
  assign bus.alu_b     = (state == S_EXEC) ? bus.rf_rdata : '0;
  assign bus.rf_wdata  = bus.rf_we ? bus.alu_result : '0;

  // Sequencer: state plus registered outputs computed for the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir          <= '0;
      a           <= '0;
      flags       <= '0;
      retired     <= '0;
      illegal     <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_we   <= 1'b0;
      bus.alu_op  <= '0;
`ifdef MINI_MICRO_CTRL_STEP_EN
      single_step <= 1'b0;
`endif
    end else begin
      bus.rf_addr <= '0;
      bus.rf_we   <= 1'b0;
      bus.alu_op  <= '0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
`ifdef MINI_MICRO_CTRL_STEP_EN
            single_step <= 1'b0;
          end else if (step) begin
            state       <= S_FETCH;
            busy        <= 1'b1;
            single_step <= 1'b1;
`endif
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir <= bus.imem_rdata;
          if (fetch_op == OP_NOP) begin
            state <= S_WB;
          end else if (fetch_op <= OP_CMP) begin
            state       <= S_RS1;
            bus.rf_addr <= fetch_rs1;
          end else begin
            state   <= S_HALT;
            illegal <= 1'b1;
            busy    <= 1'b0;
            halted  <= 1'b1;
          end
        end
        S_RS1: begin
          state       <= S_RS2;
          bus.rf_addr <= rs2;
        end
        S_RS2: begin
          state      <= S_EXEC;
          a          <= bus.rf_rdata;
          bus.alu_op <= opcode;
        end
        S_EXEC: begin
          state <= S_WB;
          if (opcode != OP_CMP) begin
            bus.rf_we   <= 1'b1;
            bus.rf_addr <= rd;
          end
        end
        S_WB: begin
          if (opcode != OP_NOP) flags <= bus.alu_flags;
          pc      <= pc + ADDR_WIDTH'(1);
          retired <= retired + CNT_WIDTH'(1);
`ifdef MINI_MICRO_CTRL_STEP_EN
          if (run && !single_step) begin
`else
          if (run) begin
`endif
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mini_micro_ctrl.sv
// Directed bench for mini_micro_ctrl with behavioural progmem, regmem and ALU.
`timescale 1ns/1ps
module tb_mini_micro_ctrl;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 16;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADDS = 5'd4;
  localparam logic [4:0] OP_CMP  = 5'd18;
  localparam logic [4:0] OP_ILL  = 5'd19;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b0;
`ifdef MINI_MICRO_CTRL_STEP_EN
  logic step = 1'b0;
`endif
  logic [3:0]    flags;
  logic          busy;
  logic          halted;
  logic          illegal;
  logic [CW-1:0] retired;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] progmem [DEPTH];
  logic [DW-1:0] regmem  [DEPTH];
  logic          mem_init = 1'b0;
  logic [DW-1:0] alu_res_c;

  mini_micro_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mini_micro_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
`ifdef MINI_MICRO_CTRL_STEP_EN
    .step    (step),
`endif
    .bus     (bus),
    .flags   (flags),
    .busy    (busy),
    .halted  (halted),
    .illegal (illegal),
    .retired (retired)
  );

  always #5 clk = ~clk;

  // Toy ALU: CMP subtracts, every other op adds; flags {N,Z,0,0}.
  always_comb begin
    alu_res_c = (bus.alu_op == OP_CMP) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
  end

  // Registered memories and ALU, 1-cycle latency.
  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) regmem[i] <= '0;
      regmem[1] <= 32'd5;
      regmem[2] <= 32'd7;
      regmem[4] <= 32'd5;
    end else if (bus.rf_we) begin
      regmem[bus.rf_addr] <= bus.rf_wdata;
    end
    bus.imem_rdata <= progmem[bus.imem_addr];
    bus.rf_rdata   <= regmem[bus.rf_addr];
    bus.alu_result <= alu_res_c;
    bus.alu_flags  <= {alu_res_c[DW-1], alu_res_c == '0, 2'b00};
  end

  function automatic logic [DW-1:0] enc(input logic [4:0] op, input logic [8:0] rd,
                                        input logic [8:0] rs1, input logic [8:0] rs2);
    return {rs2, rs1, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    run = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) progmem[i] = '0;
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    tick();
    checks++;
    if ({bus.imem_addr, bus.rf_addr, bus.rf_we, bus.rf_wdata, bus.alu_op, bus.alu_a,
         bus.alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%0h rfa=%0h we=%0b wd=%0h op=%0h a=%0h b=%0h expected all 0",
               bus.imem_addr, bus.rf_addr, bus.rf_we, bus.rf_wdata, bus.alu_op, bus.alu_a, bus.alu_b);
    end
    checks++;
    if ({flags, busy, halted, illegal, retired} !== '0) begin
      errors++;
      $display("FAIL reset_status: got flags=%0h busy=%0b halted=%0b illegal=%0b retired=%0d expected all 0",
               flags, busy, halted, illegal, retired);
    end
  endtask

  task automatic test_add();
    progmem[0] = enc(OP_ADDS, 9'd3, 9'd1, 9'd2);
    rst = 1'b1;
    run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (bus.rf_we !== (c == 6) || busy !== 1'b1) begin
        errors++;
        $display("FAIL add_cycle%0d: got we=%0b busy=%0b expected we=%0b busy=1", c, bus.rf_we, busy, c == 6);
      end
      if (c == 3) begin
        checks++;
        if (bus.rf_addr !== 9'd1) begin
          errors++;
          $display("FAIL add_rs1_addr: got %0d expected 1", bus.rf_addr);
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.alu_op !== OP_ADDS || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
          errors++;
          $display("FAIL add_exec: got op=%0d a=%0d b=%0d expected op=4 a=5 b=7", bus.alu_op, bus.alu_a, bus.alu_b);
        end
      end
      if (c == 6) begin
        checks++;
        if (bus.rf_addr !== 9'd3 || bus.rf_wdata !== 32'd12) begin
          errors++;
          $display("FAIL add_wb: got addr=%0d data=%0d expected addr=3 data=12", bus.rf_addr, bus.rf_wdata);
        end
        run = 1'b0;
      end
    end
    tick();
    checks++;
    if (retired !== 16'd1 || bus.imem_addr !== 9'd1 || busy !== 1'b0 || regmem[3] !== 32'd12 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL add_done: got retired=%0d pc=%0d busy=%0b r3=%0d flags=%b expected 1 1 0 12 0000",
               retired, bus.imem_addr, busy, regmem[3], flags);
    end
  endtask

  task automatic test_cmp();
    int we_seen = 0;
    progmem[1] = enc(OP_CMP, 9'd9, 9'd1, 9'd4);
    run = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (bus.rf_we !== 1'b0) we_seen++;
      if (c == 5) begin
        checks++;
        if (bus.alu_op !== OP_CMP) begin
          errors++;
          $display("FAIL cmp_op: got %0d expected 18", bus.alu_op);
        end
      end
      if (c == 6) run = 1'b0;
    end
    checks++;
    if (we_seen != 0) begin
      errors++;
      $display("FAIL cmp_no_write: got %0d write cycles expected 0", we_seen);
    end
    tick();
    checks++;
    if (flags !== 4'b0100 || bus.imem_addr !== 9'd2 || retired !== 16'd2 || regmem[9] !== 32'd0) begin
      errors++;
      $display("FAIL cmp_done: got flags=%b pc=%0d retired=%0d r9=%0d expected 0100 2 2 0",
               flags, bus.imem_addr, retired, regmem[9]);
    end
  endtask

  task automatic test_run_drop();
    progmem[2] = enc(OP_ADDS, 9'd5, 9'd1, 9'd2);
    run = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.rf_addr !== 9'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_in_rs1: got addr=%0d busy=%0b expected 1 1", bus.rf_addr, busy);
    end
    run = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_addr !== 9'd5 || bus.rf_wdata !== 32'd12) begin
      errors++;
      $display("FAIL drop_wb: got we=%0b addr=%0d data=%0d expected 1 5 12", bus.rf_we, bus.rf_addr, bus.rf_wdata);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || retired !== 16'd3 || bus.imem_addr !== 9'd3 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL drop_idle: got busy=%0b retired=%0d pc=%0d flags=%b expected 0 3 3 0000",
               busy, retired, bus.imem_addr, flags);
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || bus.imem_addr !== 9'd3) begin
      errors++;
      $display("FAIL drop_stay_idle: got busy=%0b pc=%0d expected 0 3", busy, bus.imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    int bad_busy = 0;
    progmem[3] = enc(OP_ADDS, 9'd6, 9'd5, 9'd2);
    progmem[4] = enc(OP_CMP, 9'd0, 9'd6, 9'd6);
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (busy !== 1'b1) bad_busy++;
      checks++;
      if (bus.rf_we !== (c == 6)) begin
        errors++;
        $display("FAIL b2b_we_cycle%0d: got %0b expected %0b", c, bus.rf_we, c == 6);
      end
      if (c == 6) begin
        checks++;
        if (bus.rf_wdata !== 32'd19) begin
          errors++;
          $display("FAIL b2b_wdata: got %0d expected 19", bus.rf_wdata);
        end
      end
      if (c == 7) begin
        checks++;
        if (bus.imem_addr !== 9'd4) begin
          errors++;
          $display("FAIL b2b_next_fetch: got pc=%0d expected 4", bus.imem_addr);
        end
      end
      if (c == 12) run = 1'b0;
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL b2b_busy: got %0d idle cycles expected 0", bad_busy);
    end
    tick();
    checks++;
    if (flags !== 4'b0100 || retired !== 16'd5 || bus.imem_addr !== 9'd5 || busy !== 1'b0 || regmem[6] !== 32'd19) begin
      errors++;
      $display("FAIL b2b_done: got flags=%b retired=%0d pc=%0d busy=%0b r6=%0d expected 0100 5 5 0 19",
               flags, retired, bus.imem_addr, busy, regmem[6]);
    end
  endtask

  task automatic test_reset_mid_wb();
    progmem[5] = enc(OP_ADDS, 9'd8, 9'd1, 9'd2);
    run = 1'b1;
    for (int c = 1; c <= 6; c++) tick();
    checks++;
    if (bus.rf_we !== 1'b1) begin
      errors++;
      $display("FAIL rstwb_pre: got we=%0b expected 1", bus.rf_we);
    end
    #2;
    rst = 1'b0;
    run = 1'b0;
    #1;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_wdata !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstwb_async: got we=%0b wd=%0h busy=%0b expected 0 0 0", bus.rf_we, bus.rf_wdata, busy);
    end
    checks++;
    if (bus.imem_addr !== 9'd0 || flags !== 4'b0000 || retired !== 16'd0) begin
      errors++;
      $display("FAIL rstwb_state: got pc=%0d flags=%b retired=%0d expected 0 0000 0", bus.imem_addr, flags, retired);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (regmem[8] !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstwb_dropped: got r8=%0d busy=%0b expected 0 0", regmem[8], busy);
    end
  endtask

  task automatic test_halt();
    int bad = 0;
    progmem[0] = enc(OP_NOP, 9'd0, 9'd0, 9'd0);
    progmem[1] = enc(OP_ILL, 9'd0, 9'd0, 9'd0);
    run = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.rf_we !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL nop_wb: got we=%0b busy=%0b expected 0 1", bus.rf_we, busy);
    end
    tick();
    checks++;
    if (bus.imem_addr !== 9'd1 || retired !== 16'd1) begin
      errors++;
      $display("FAIL nop_retire: got pc=%0d retired=%0d expected 1 1", bus.imem_addr, retired);
    end
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || illegal !== 1'b1 || busy !== 1'b0 || bus.imem_addr !== 9'd1 ||
        retired !== 16'd1 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL halt_enter: got halted=%0b illegal=%0b busy=%0b pc=%0d retired=%0d flags=%b expected 1 1 0 1 1 0000",
               halted, illegal, busy, bus.imem_addr, retired, flags);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      if (halted !== 1'b1 || busy !== 1'b0 || bus.imem_addr !== 9'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_pc_wrap();
    int n = 0;
    run = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (halted !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL wrap_reset: got halted=%0b illegal=%0b expected 0 0", halted, illegal);
    end
    for (int i = 0; i < int'(DEPTH); i++) progmem[i] = '0;
    progmem[DEPTH-1] = enc(OP_ADDS, 9'd10, 9'd1, 9'd2);
    run = 1'b1;
    while (n < 2000 && bus.imem_addr !== 9'd511) begin
      tick();
      n++;
    end
    checks++;
    if (bus.imem_addr !== 9'd511) begin
      errors++;
      $display("FAIL wrap_reach: got pc=%0d expected 511 within 2000 cycles", bus.imem_addr);
    end
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'd12) begin
      errors++;
      $display("FAIL wrap_wb: got we=%0b data=%0d expected 1 12", bus.rf_we, bus.rf_wdata);
    end
    tick();
    checks++;
    if (bus.imem_addr !== 9'd0 || busy !== 1'b1 || retired !== 16'd512) begin
      errors++;
      $display("FAIL wrap_pc: got pc=%0d busy=%0b retired=%0d expected 0 1 512", bus.imem_addr, busy, retired);
    end
    run = 1'b0;
    tick();
    tick();
    tick();
  endtask

`ifdef MINI_MICRO_CTRL_STEP_EN
  task automatic test_step();
    run = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    progmem[0] = enc(OP_ADDS, 9'd11, 9'd1, 9'd2);
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL step_start: got busy=%0b expected 1", busy);
    end
    for (int c = 0; c < 12; c++) tick();
    checks++;
    if (retired !== 16'd1 || busy !== 1'b0 || regmem[11] !== 32'd12) begin
      errors++;
      $display("FAIL step_one: got retired=%0d busy=%0b r11=%0d expected 1 0 12", retired, busy, regmem[11]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_run_drop();
    test_back_to_back();
    test_reset_mid_wb();
    test_halt();
    test_pc_wrap();
`ifdef MINI_MICRO_CTRL_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
